quad_encoder_gen: RTL and testbench

//  Quadrature encoder signal generator: the transmit end of the quad_A/quad_B/quad_I

---
 rtl/quad_encoder_gen_if.sv | 22 ++
 rtl/quad_encoder_gen.sv | 162 ++++++++++++++++
 tb/tb_quad_encoder_gen.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_gen_if.sv
// Register bus shared by the quadrature generator, pwm and motion channels.
// Read data from every unit on the bus is OR-combined by the fabric.
interface quad_encoder_gen_if;
   logic [7:0]  reg_address;
   logic [31:0] reg_in;
   logic        reg_wr;
   logic [31:0] reg_out;

   modport master (
      output reg_address,
      output reg_in,
      output reg_wr,
      input  reg_out
   );

   modport slave (
      input  reg_address,
      input  reg_in,
      input  reg_wr,
      output reg_out
   );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: emits programmable-rate, programmable-length A/B/I
// step sequences in either direction, configured over the shared register bus.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  ST_IDLE | stopped; A/B/I hold their last levels
//  ST_RUN  | stepping once every PERIOD cycles; busy high
//  ST_DONE | finite run completed; done=1, enable cleared, outputs hold
module quad_encoder_gen #(
   parameter int unsigned GEN_UNIT       = 0,
   parameter logic [7:0]  BASE_ADDR      = 8'h40,
   parameter int unsigned COUNTS_PER_REV = 1024
) (
   input  logic              clk,
   input  logic              reset,
   quad_encoder_gen_if.slave bus,
   output logic              quad_A,
   output logic              quad_B,
   output logic              quad_I,
   output logic              busy
);

   localparam logic [7:0]       UNIT_BASE = BASE_ADDR + 8'(4 * GEN_UNIT);
   localparam int               REV_W     = (COUNTS_PER_REV > 2) ? $clog2(COUNTS_PER_REV) : 1;
   localparam logic [REV_W-1:0] REV_MAX   = REV_W'(COUNTS_PER_REV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic             cfg_enable;
   logic             cfg_dir;
   logic             cfg_index_en;
   logic             done;
   logic             finite_mode;
   logic [15:0]      period;
   logic [15:0]      tick;
   logic [31:0]      remaining;
   logic [31:0]      position;
   logic [1:0]       phase;
   logic [REV_W-1:0] rev_cnt;

   logic             unit_hit;
   logic [1:0]       offset;
   logic             wr_cfg;
   logic             wr_period;
   logic             wr_steps;
   logic             wr_pos;
   logic [15:0]      period_eff;
   logic             step;
   logic [1:0]       phase_nxt;
   logic [REV_W-1:0] rev_nxt;

   // Unit base is 4-aligned, so the upper six address bits select the unit.
   assign unit_hit  = (bus.reg_address[7:2] == UNIT_BASE[7:2]);
   assign offset    = bus.reg_address[1:0];
   assign wr_cfg    = bus.reg_wr & unit_hit & (offset == 2'd0);
   assign wr_period = bus.reg_wr & unit_hit & (offset == 2'd1);
   assign wr_steps  = bus.reg_wr & unit_hit & (offset == 2'd2);
   assign wr_pos    = bus.reg_wr & unit_hit & (offset == 2'd3);

   // >= rather than == so a PERIOD shrunk below the current tick steps next cycle.
   assign period_eff = (period < 16'd2) ? 16'd2 : period;
   assign step       = (state == ST_RUN) && (tick >= (period_eff - 16'd1));
   assign phase_nxt  = cfg_dir ? (phase - 2'd1) : (phase + 2'd1);
   assign busy       = (state == ST_RUN);

   always_comb begin
      rev_nxt = rev_cnt;
      if (cfg_dir) begin
         rev_nxt = (rev_cnt == '0) ? REV_MAX : (rev_cnt - REV_W'(1));
      end else begin
         rev_nxt = (rev_cnt == REV_MAX) ? '0 : (rev_cnt + REV_W'(1));
      end
   end

   always_comb begin
      bus.reg_out = '0;
      if (unit_hit) begin
         case (offset)
            2'd0:    bus.reg_out = {23'd0, done, 5'd0, cfg_index_en, cfg_dir, cfg_enable};
            2'd1:    bus.reg_out = {16'd0, period};
            2'd2:    bus.reg_out = remaining;
            default: bus.reg_out = position;
         endcase
      end
   end

   // Step logic runs on pre-write values; register writes below override it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         cfg_enable   <= 1'b0;
         cfg_dir      <= 1'b0;
         cfg_index_en <= 1'b0;
         done         <= 1'b0;
         finite_mode  <= 1'b0;
         period       <= '0;
         tick         <= '0;
         remaining    <= '0;
         position     <= '0;
         phase        <= 2'd0;
         rev_cnt      <= '0;
         quad_A       <= 1'b0;
         quad_B       <= 1'b0;
         quad_I       <= 1'b0;
      end else begin
         if (step) begin
            tick     <= '0;
            phase    <= phase_nxt;
            quad_A   <= phase_nxt[0] ^ phase_nxt[1];
            quad_B   <= phase_nxt[1];
            quad_I   <= cfg_index_en & (rev_nxt == '0) & (phase_nxt == 2'd0);
            rev_cnt  <= rev_nxt;
            position <= cfg_dir ? (position - 32'd1) : (position + 32'd1);
            if (finite_mode) begin
               remaining <= (remaining == 32'd0) ? 32'd0 : (remaining - 32'd1);
               if (remaining <= 32'd1) begin
                  state      <= ST_DONE;
                  cfg_enable <= 1'b0;
                  done       <= 1'b1;
               end
            end
         end else if (state == ST_RUN) begin
            tick <= tick + 16'd1;
         end

         if (wr_cfg) begin
            cfg_enable   <= bus.reg_in[0];
            cfg_dir      <= bus.reg_in[1];
            cfg_index_en <= bus.reg_in[2];
            if (bus.reg_in[0]) begin
               state <= ST_RUN;
               done  <= 1'b0;
               // Re-writing CONFIG while running (e.g. a dir change) keeps the step cadence.
               if (state != ST_RUN) begin
                  tick        <= '0;
                  finite_mode <= (remaining != 32'd0);
               end
            end else begin
               state <= ST_IDLE;
               if (state == ST_RUN) begin
                  done <= 1'b0;
               end
            end
         end
         if (wr_period) begin
            period <= bus.reg_in[15:0];
         end
         if (wr_steps) begin
            remaining <= bus.reg_in;
         end
         if (wr_pos) begin
            position <= bus.reg_in;
         end
      end
   end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: register table vectors plus an A/B edge
// scoreboard fed by a small quadrature model.
module tb_quad_encoder_gen;

   localparam logic [7:0] A_CFG = 8'h44;
   localparam logic [7:0] A_PER = 8'h45;
   localparam logic [7:0] A_STP = 8'h46;
   localparam logic [7:0] A_POS = 8'h47;
   localparam int         CPR   = 4;
   localparam int         NV    = 12;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic quad_A, quad_B, quad_I, busy;

   quad_encoder_gen_if bus ();

   quad_encoder_gen #(
      .GEN_UNIT      (1),
      .BASE_ADDR     (8'h40),
      .COUNTS_PER_REV(CPR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .quad_A(quad_A),
      .quad_B(quad_B),
      .quad_I(quad_I),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int unexp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] ab;
      logic       i;
      int         off;
   } edge_t;

   edge_t      sb[$];
   edge_t      e_mon;
   int         sb_base = 0;
   bit         mon_en = 1'b0;
   logic [1:0] prev_ab = 2'b00;

   always @(negedge clk) begin
      if (mon_en && ({quad_A, quad_B} != prev_ab)) begin
         if (sb.size() == 0) begin
            unexp++;
         end else begin
            e_mon = sb.pop_front();
            check("edge_ab", {30'd0, quad_A, quad_B}, {30'd0, e_mon.ab});
            check("edge_index", {31'd0, quad_I}, {31'd0, e_mon.i});
            check("edge_cycle", cyc, sb_base + e_mon.off);
         end
      end
      prev_ab = {quad_A, quad_B};
   end

   logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int          m_p   = 0;
   int          m_rev = 0;
   logic [31:0] m_pos = 32'd0;

   task automatic push_steps(input int n, input bit dir, input bit idx, input int per);
      edge_t e;
      for (int k = 1; k <= n; k++) begin
         if (dir) begin
            m_p   = (m_p + 3) % 4;
            m_rev = (m_rev + CPR - 1) % CPR;
            m_pos = m_pos - 32'd1;
         end else begin
            m_p   = (m_p + 1) % 4;
            m_rev = (m_rev + 1) % CPR;
            m_pos = m_pos + 32'd1;
         end
         e.ab  = ab_tab[m_p];
         e.i   = idx && (m_rev == 0) && (m_p == 0);
         e.off = k * per;
         sb.push_back(e);
      end
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [31:0] d, output int wc);
      @(negedge clk);
      bus.reg_address = a;
      bus.reg_in      = d;
      bus.reg_wr      = 1'b1;
      @(negedge clk);
      bus.reg_wr = 1'b0;
      wc = cyc;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.reg_address = a;
      #1 d = bus.reg_out;
   endtask

   task automatic wait_sb(input string name, input int maxc);
      int n = 0;
      while (sb.size() != 0 && n < maxc) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(name, sb.size(), 0);
      sb.delete();
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic        do_wr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t        vecs [NV];
   int          wc;
   logic [31:0] d;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{A_CFG, 1'b0, 32'h0,          32'h0,          "rst_config"};
      vecs[1]  = '{A_PER, 1'b0, 32'h0,          32'h0,          "rst_period"};
      vecs[2]  = '{A_STP, 1'b0, 32'h0,          32'h0,          "rst_steps"};
      vecs[3]  = '{A_POS, 1'b0, 32'h0,          32'h0,          "rst_position"};
      vecs[4]  = '{8'h40, 1'b0, 32'h0,          32'h0,          "other_unit_read"};
      vecs[5]  = '{A_PER, 1'b1, 32'h000A_BCDE,  32'h0000_BCDE,  "period_16bit"};
      vecs[6]  = '{A_STP, 1'b1, 32'h0000_0007,  32'h0000_0007,  "steps_rw"};
      vecs[7]  = '{A_POS, 1'b1, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  "position_rw"};
      vecs[8]  = '{A_CFG, 1'b1, 32'h0000_0106,  32'h0000_0006,  "config_rw_done_ro"};
      vecs[9]  = '{8'h48, 1'b1, 32'hFFFF_FFFF,  32'h0,          "out_of_range_write"};
      vecs[10] = '{A_CFG, 1'b1, 32'h0,          32'h0,          "config_clear"};
      vecs[11] = '{8'h43, 1'b0, 32'h0,          32'h0,          "below_range_read"};

      bus.reg_address = 8'h00;
      bus.reg_in      = 32'h0;
      bus.reg_wr      = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      check("rst_quad_ab", {30'd0, quad_A, quad_B}, 32'd0);
      check("rst_quad_i", {31'd0, quad_I}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].do_wr) reg_write(vecs[i].addr, vecs[i].wdata, wc);
         reg_read(vecs[i].addr, d);
         check(vecs[i].name, d, vecs[i].exp);
      end

      // Finite forward run: 8 steps, 10 clk apart, first edge 10 clk after the enable write.
      mon_en = 1'b1;
      reg_write(A_PER, 32'd10, wc);
      reg_write(A_STP, 32'd8, wc);
      reg_write(A_POS, 32'd0, wc);
      m_pos = 32'd0;
      push_steps(8, 1'b0, 1'b0, 10);
      reg_write(A_CFG, 32'h1, wc);
      sb_base = wc;
      check("fwd_busy_running", {31'd0, busy}, 32'd1);
      wait_sb("fwd_edges_seen", 200);
      wait_idle("fwd_busy_low", 20);
      reg_read(A_POS, d);  check("fwd_position", d, 32'd8);
      reg_read(A_CFG, d);  check("fwd_done", d, 32'h100);
      reg_read(A_STP, d);  check("fwd_remaining", d, 32'd0);

      // Reverse run of 3 from position 0.
      reg_write(A_POS, 32'd0, wc);
      m_pos = 32'd0;
      reg_write(A_STP, 32'd3, wc);
      push_steps(3, 1'b1, 1'b0, 10);
      reg_write(A_CFG, 32'h3, wc);
      sb_base = wc;
      wait_sb("rev_edges_seen", 100);
      wait_idle("rev_busy_low", 20);
      reg_read(A_POS, d);  check("rev_position", d, 32'hFFFF_FFFD);
      reg_read(A_CFG, d);  check("rev_done_dir", d, 32'h102);

      // Index alignment, continuous forward then reverse.
      reg_write(A_PER, 32'd4, wc);
      reg_write(A_STP, 32'd0, wc);
      push_steps(8, 1'b0, 1'b1, 4);
      reg_write(A_CFG, 32'h5, wc);
      sb_base = wc;
      wait_sb("idx_fwd_edges_seen", 100);
      reg_write(A_CFG, 32'h0, wc);
      push_steps(8, 1'b1, 1'b1, 4);
      reg_write(A_CFG, 32'h7, wc);
      sb_base = wc;
      wait_sb("idx_rev_edges_seen", 100);
      reg_write(A_CFG, 32'h0, wc);
      check("idx_busy_after_abort", {31'd0, busy}, 32'd0);

      // Abort mid-period during a finite run.
      reg_write(A_PER, 32'd20, wc);
      reg_write(A_STP, 32'd50, wc);
      push_steps(2, 1'b0, 1'b0, 20);
      reg_write(A_CFG, 32'h1, wc);
      sb_base = wc;
      wait_sb("abort_edges_seen", 100);
      repeat (5) @(negedge clk);
      reg_write(A_CFG, 32'h0, wc);
      repeat (60) @(negedge clk);
      check("abort_no_edges", unexp, 0);
      check("abort_ab_hold", {30'd0, quad_A, quad_B}, {30'd0, ab_tab[m_p]});
      check("abort_busy", {31'd0, busy}, 32'd0);
      reg_read(A_CFG, d);  check("abort_config_done0", d, 32'h0);
      reg_read(A_STP, d);  check("abort_remaining", d, 32'd48);

      // PERIOD=0 behaves as 2.
      reg_write(A_PER, 32'd0, wc);
      reg_write(A_STP, 32'd4, wc);
      push_steps(4, 1'b0, 1'b0, 2);
      reg_write(A_CFG, 32'h1, wc);
      sb_base = wc;
      wait_sb("per0_edges_seen", 50);
      wait_idle("per0_busy_low", 20);
      reg_read(A_POS, d);  check("per0_position", d, m_pos);

      // POSITION write landing on the same edge as a step: the written value wins.
      reg_write(A_PER, 32'd10, wc);
      reg_write(A_STP, 32'd1, wc);
      push_steps(1, 1'b0, 1'b0, 10);
      reg_write(A_CFG, 32'h1, wc);
      sb_base = wc;
      while (cyc < sb_base + 8) @(negedge clk);
      reg_write(A_POS, 32'h1234_0000, wc);
      check("pos_write_edge_cycle", wc, sb_base + 10);
      m_pos = 32'h1234_0000;
      wait_sb("poswr_edges_seen", 50);
      wait_idle("poswr_busy_low", 20);
      reg_read(A_POS, d);  check("poswr_position", d, 32'h1234_0000);
      reg_read(A_CFG, d);  check("poswr_done", d, 32'h100);

      // Asynchronous reset in the middle of a run.
      mon_en = 1'b0;
      reg_write(A_PER, 32'd5, wc);
      reg_write(A_STP, 32'd0, wc);
      reg_write(A_CFG, 32'h7, wc);
      for (int n = 0; n < 50 && !(quad_A | quad_B); n++) @(negedge clk);
      check("mid_run_busy", {31'd0, busy}, 32'd1);
      check("mid_run_ab_nonzero", {31'd0, quad_A | quad_B}, 32'd1);
      bus.reg_address = A_CFG;
      #2 reset = 1'b0;
      #1;
      check("arst_quad_ab", {30'd0, quad_A, quad_B}, 32'd0);
      check("arst_quad_i", {31'd0, quad_I}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_config", bus.reg_out, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      reg_read(A_POS, d);  check("arst_position", d, 32'd0);
      reg_read(A_PER, d);  check("arst_period", d, 32'd0);
      repeat (10) @(negedge clk);
      check("arst_stays_idle", {29'd0, quad_A, quad_B, busy}, 32'd0);

      check("unexpected_edges_total", unexp, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
